// File: rtl/i2s_mic_array_rx_if.sv
// Completed-frame handshake between the mic array receiver and its consumer.
// The master drives frame_data/frame_vld, and the slave returns frame_rdy.
interface i2s_mic_array_rx_if #(
   parameter int FRAME_W = 144
) ();
   logic [FRAME_W-1:0] frame_data;
   logic               frame_vld;
   logic               frame_rdy;

   modport master (output frame_data, output frame_vld, input frame_rdy);
   modport slave  (input frame_data, input frame_vld, output frame_rdy);
endinterface

// File: rtl/i2s_mic_array_rx.sv
// I2S / left-justified master receiver for a MEMS mic array.
// Generates sck/ws from clk and packs one frame of 2*NUM_LINES samples.
//
// state  | meaning
// S_IDLE | disabled; sck low, ws high, counters cleared
// S_LEAD | divider running, waiting for the first sck falling edge
// S_RUN  | framing active; ws follows the sck cycle index, data captured
module i2s_mic_array_rx #(
   parameter int NUM_LINES = 3,
   parameter int DATA_W    = 24,
   parameter int SLOT_W    = 32,
   parameter int SCK_DIV   = 4,
   parameter int FMT_LJ    = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_en,
   input  logic [NUM_LINES-1:0] i_mic_sdin,
   output logic                 o_mic_sck,
   output logic                 o_mic_ws,
   output logic                 o_overrun,
   input  logic                 i_ovr_clr,
   i2s_mic_array_rx_if.master   frm
);
   localparam int FRAME_W = 2 * NUM_LINES * DATA_W;
   localparam int DIV_W   = $clog2(SCK_DIV);
   localparam int N_W     = $clog2(2 * SLOT_W) + 1;
   localparam int OFF     = (FMT_LJ != 0) ? 0 : 1;

   localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(SCK_DIV / 2 - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
   localparam logic [N_W-1:0]   L_FIRST  = N_W'(OFF);
   localparam logic [N_W-1:0]   L_END    = N_W'(OFF + DATA_W);
   localparam logic [N_W-1:0]   R_FIRST  = N_W'(SLOT_W + OFF);
   localparam logic [N_W-1:0]   R_END    = N_W'(SLOT_W + OFF + DATA_W);
   localparam logic [N_W-1:0]   R_LAST   = N_W'(SLOT_W + OFF + DATA_W - 1);
   localparam logic [N_W-1:0]   N_HALF   = N_W'(SLOT_W);
   localparam logic [N_W-1:0]   N_LAST   = N_W'(2 * SLOT_W - 1);

   if ((SCK_DIV < 2) || ((SCK_DIV % 2) != 0)) begin : g_bad_div
      $error("SCK_DIV must be even and at least 2");
   end
   if ((DATA_W < 2) || (DATA_W > SLOT_W - OFF)) begin : g_bad_width
      $error("DATA_W does not fit in the slot for this format");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LEAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [DIV_W-1:0]     r_div;
   logic                 r_sck;
   logic                 r_ws;
   logic [N_W-1:0]       r_n;
   logic [N_W-1:0]       w_n_nxt;
   logic                 w_rise;
   logic                 w_wrap;
   logic                 w_sample;
   logic                 w_take_l;
   logic                 w_take_r;
   logic                 w_last;
   logic                 r_done;
   logic [DATA_W-1:0]    r_sh_l [NUM_LINES];
   logic [DATA_W-1:0]    r_sh_r [NUM_LINES];
   logic [FRAME_W-1:0]   w_pack;
   logic [FRAME_W-1:0]   r_frame_data;
   logic                 r_frame_vld;
   logic                 r_overrun;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rise      = (r_div == DIV_RISE);
      w_wrap      = (r_div == DIV_LAST);
      w_sample    = 1'b0;
      w_n_nxt     = '0;
      w_take_l    = 1'b0;
      w_take_r    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: if (i_en) w_state_nxt = S_LEAD;
         S_LEAD: begin
            if (!i_en)       w_state_nxt = S_IDLE;
            else if (w_wrap) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (!i_en) w_state_nxt = S_IDLE;
            w_sample = i_en && w_rise;
            w_n_nxt  = (r_n == N_LAST) ? '0 : r_n + N_W'(1);
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // Slot bits outside the captured window (I2S lead bit, padding) are skipped.
      w_take_l = w_sample && (r_n >= L_FIRST) && (r_n < L_END);
      w_take_r = w_sample && (r_n >= R_FIRST) && (r_n < R_END);
      w_last   = w_sample && (r_n == R_LAST);
   end

   // ws only changes on falling sck edges; n counts sck cycles within the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
         r_sck <= 1'b0;
         r_ws  <= 1'b1;
         r_n   <= '0;
      end else if (!i_en) begin
         r_div <= '0;
         r_sck <= 1'b0;
         r_ws  <= 1'b1;
         r_n   <= '0;
      end else begin
         r_div <= w_wrap ? '0 : r_div + DIV_W'(1);
         if (w_rise) begin
            r_sck <= 1'b1;
         end else if (w_wrap) begin
            r_sck <= 1'b0;
         end
         if (w_wrap) begin
            r_n  <= w_n_nxt;
            r_ws <= (w_n_nxt >= N_HALF);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            r_sh_l[i] <= '0;
            r_sh_r[i] <= '0;
         end
         r_done <= 1'b0;
      end else if (!i_en) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            r_sh_l[i] <= '0;
            r_sh_r[i] <= '0;
         end
         r_done <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_LINES; i++) begin
            if (w_take_l) r_sh_l[i] <= {r_sh_l[i][DATA_W-2:0], i_mic_sdin[i]};
            if (w_take_r) r_sh_r[i] <= {r_sh_r[i][DATA_W-2:0], i_mic_sdin[i]};
         end
         r_done <= w_last;
      end
   end

   always_comb begin
      w_pack = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         w_pack[(2 * i) * DATA_W +: DATA_W]     = r_sh_l[i];
         w_pack[(2 * i + 1) * DATA_W +: DATA_W] = r_sh_r[i];
      end
   end

   // A finished frame always lands, even when the previous one is still pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_data <= '0;
         r_frame_vld  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (r_done) begin
            r_frame_data <= w_pack;
            r_frame_vld  <= 1'b1;
         end else if (r_frame_vld && frm.frame_rdy) begin
            r_frame_vld  <= 1'b0;
         end
         if (r_done && r_frame_vld && !frm.frame_rdy) begin
            r_overrun <= 1'b1;
         end else if (i_ovr_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign o_mic_sck      = r_sck;
   assign o_mic_ws       = r_ws;
   assign o_overrun      = r_overrun;
   assign frm.frame_data = r_frame_data;
   assign frm.frame_vld  = r_frame_vld;
endmodule
